// File: rtl/exec_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : exec_writeback_unit
// Description : Execute/writeback stage. Owns the 8x16 register file, runs
//               single-cycle ALU ops through a one-stage EX register, writes
//               back one cycle later and forwards the in-flight result.
//               Optional iterative shift-add multiply (opcode 7) stalls the
//               front end while it runs; enabled by defining EXEC_MUL_EN.
//               Without EXEC_MUL_EN opcode 7 is a NOP and stall is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_writeback_unit #(
    parameter int DATA_W     = 16,
    parameter int NREGS      = 8,
    parameter int MUL_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    input  logic [3:0]                 opcode,
    input  logic [$clog2(NREGS)-1:0]   rs1,
    input  logic [$clog2(NREGS)-1:0]   rs2,
    input  logic [$clog2(NREGS)-1:0]   rd,
    input  logic [5:0]                 imm,
    input  logic                       src2_sel,
    input  logic                       out_sel,
    input  logic                       reg_we,
    output logic                       stall,
    output logic                       wb_valid,
    output logic [$clog2(NREGS)-1:0]   wb_addr,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       zero_flag,
    output logic                       carry_flag,
    input  logic [$clog2(NREGS)-1:0]   dbg_addr,
    output logic [DATA_W-1:0]          dbg_data
);

    localparam int         c_AW     = $clog2(NREGS);
    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_SLL = 4'd5;
    localparam logic [3:0] c_OP_SRL = 4'd6;
    localparam logic [3:0] c_OP_MUL = 4'd7;

    // Elaboration-time sanity check on the configuration
    if ((MUL_CYCLES < 1) || (DATA_W < 6)) begin : g_cfg_check
        $error("exec_writeback_unit: MUL_CYCLES must be >= 1 and DATA_W >= 6");
    end

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_wb_valid;
    logic [c_AW-1:0]   r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_zero;
    logic              r_carry;

    logic              w_stall;
    logic              w_accept;
    logic              w_single;
    logic              w_is_alu;
    logic              w_alu_carry;
    logic [DATA_W-1:0] w_imm_ext;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_rf_b;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu_res;

    assign w_imm_ext = {{(DATA_W-6){imm[5]}}, imm};

    // Operand fetch: r0 reads zero, pending EX result overrides the file
    always_comb begin
        w_op_a = r_regs[rs1];
        if (rs1 == '0) begin
            w_op_a = '0;
        end else if (r_wb_valid && (r_wb_addr == rs1)) begin
            w_op_a = r_wb_data;
        end
        w_rf_b = r_regs[rs2];
        if (rs2 == '0) begin
            w_rf_b = '0;
        end else if (r_wb_valid && (r_wb_addr == rs2)) begin
            w_rf_b = r_wb_data;
        end
        w_op_b = src2_sel ? w_imm_ext : w_rf_b;
    end

    // Single-cycle ALU; multiply is handled by the iterative unit below
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_is_alu    = 1'b1;
        case (opcode)
            c_OP_ADD: {w_alu_carry, w_alu_res} = {1'b0, w_op_a} + {1'b0, w_op_b};
            c_OP_SUB: begin
                w_alu_res   = w_op_a - w_op_b;
                w_alu_carry = (w_op_a < w_op_b);
            end
            c_OP_AND: w_alu_res = w_op_a & w_op_b;
            c_OP_OR:  w_alu_res = w_op_a | w_op_b;
            c_OP_XOR: w_alu_res = w_op_a ^ w_op_b;
            c_OP_SLL: w_alu_res = w_op_a << w_op_b[3:0];
            c_OP_SRL: w_alu_res = w_op_a >> w_op_b[3:0];
            default:  w_is_alu  = 1'b0;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int                 c_CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stall;
    logic [DATA_W-1:0]  r_mcand;
    logic [DATA_W-1:0]  r_mplier;
    logic [DATA_W-1:0]  r_acc;
    logic [c_AW-1:0]    r_mul_rd;
    logic               r_mul_we;

    logic               w_start_mul;
    logic               w_mul_done;
    logic [DATA_W-1:0]  w_acc_next;

    assign w_accept    = in_valid & ~r_stall;
    // Opcode 7 with out_sel=1 is a plain load-immediate and needs no multiply
    assign w_start_mul = w_accept & (opcode == c_OP_MUL) & ~out_sel;
    assign w_single    = w_accept & (w_is_alu | ((opcode == c_OP_MUL) & out_sel));
    assign w_mul_done  = (r_state == ST_MUL) && (r_cnt == '0);
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_stall     = r_stall;

    // Multiply FSM: one shift-add step per cycle, LSB of multiplier first
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_stall  <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mul_rd <= '0;
            r_mul_we <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_mul) begin
                        r_state  <= ST_MUL;
                        r_cnt    <= c_CNT_LOAD;
                        r_stall  <= 1'b1;
                        r_mcand  <= w_op_a;
                        r_mplier <= w_op_b;
                        r_acc    <= '0;
                        r_mul_rd <= rd;
                        r_mul_we <= reg_we;
                    end
                end
                ST_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_stall <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end
`else
    assign w_stall  = 1'b0;
    assign w_accept = in_valid;
    assign w_single = w_accept & w_is_alu;
`endif

    // EX register, flags and register-file writeback
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
        end else begin
            if (r_wb_valid) begin
                r_regs[r_wb_addr] <= r_wb_data;
            end
            r_wb_valid <= 1'b0;
            if (w_single) begin
                r_wb_valid <= reg_we && (rd != '0);
                r_wb_addr  <= rd;
                r_wb_data  <= out_sel ? w_imm_ext : w_alu_res;
                if (!out_sel) begin
                    r_zero  <= (w_alu_res == '0);
                    r_carry <= w_alu_carry;
                end
            end
`ifdef EXEC_MUL_EN
            else if (w_mul_done) begin
                r_wb_valid <= r_mul_we && (r_mul_rd != '0);
                r_wb_addr  <= r_mul_rd;
                r_wb_data  <= w_acc_next;
                r_zero     <= (w_acc_next == '0);
                r_carry    <= 1'b0;
            end
`endif
        end
    end

    assign stall      = w_stall;
    assign wb_valid   = r_wb_valid;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;
    assign dbg_data   = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: doc/exec_writeback_unit.md
Name: exec_writeback_unit

Overview:
- Execute/writeback stage directly downstream of the processor's fetch/decode control logic.
- Consumes the decoded fields (opcode, read/write register selects, 6-bit immediate, source-2 select, output select, register-write flag) and owns the 8x16 register file.
- Computes ALU results through a one-stage EX register, writes back one cycle later, forwards the in-flight result, and stalls the front end during iterative multiply.

Parameters:
- DATA_W, 16, datapath and register width
- NREGS, 8, number of architectural registers (addressed by 3 bits)
- MUL_CYCLES, 16, iterations of shift-add multiply (one multiplier bit per cycle)

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  reset, synchronous, active-low
- in_valid  input  1  decoded instruction present this cycle
- opcode  input  4  operation select
- rs1  input  3  source register 1 address
- rs2  input  3  source register 2 address
- rd  input  3  destination register address
- imm  input  6  immediate, two's complement
- src2_sel  input  1  0: operand B = reg[rs2]; 1: operand B = sign-extended imm
- out_sel  input  1  0: write ALU result; 1: write sign-extended imm (load-immediate)
- reg_we  input  1  register write enable from decode
- stall  output  1  front end must hold PC/IR; registered
- wb_valid  output  1  EX register holds a write this cycle
- wb_addr  output  3  destination of pending write
- wb_data  output  16  data of pending write
- zero_flag  output  1  last ALU result was zero
- carry_flag  output  1  ADD carry-out / SUB borrow
- dbg_addr  input  3  debug read address
- dbg_data  output  16  reg[dbg_addr], combinational, post-writeback (no forwarding)

Behaviour:
- Accept when in_valid=1 and stall=0; inputs are ignored otherwise.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SLL A by B[3:0], 6 SRL A by B[3:0], 7 MUL (low 16 bits of A*B), 8-15 NOP.
- Operand A = reg[rs1]. Operand B is selected by src2_sel.
- r0 always reads 0; writes to r0 are dropped (wb_valid stays 0).
- Forwarding: when wb_valid=1 and wb_addr equals rs1 or rs2 (nonzero), the operand takes wb_data instead of the file value.
- Single-cycle ops accepted in cycle T:
  - EX register loads at the edge ending T, so wb_valid/wb_addr/wb_data are visible in T+1.
  - The register file is written at the edge ending T+1.
- wb_valid = reg_we && rd!=0 && opcode not NOP. With out_sel=1, wb_data = sign-extended imm and flags are unchanged.
- Flags update only when an ALU op (0-7) with out_sel=0 completes. Carry is 0 for ops 2-7.
- FSM IDLE/MUL:
  - Accepted MUL: latch A, B, rd, reg_we; go to MUL; a counter loads MUL_CYCLES-1.
  - In MUL: stall=1; one add-shift per cycle; the counter decrements.
  - When the counter reaches 0 (cycle T+MUL_CYCLES), the EX register loads the product and FSM returns to IDLE.
  - Result is visible as wb_valid in T+MUL_CYCLES+1, with stall=0 in that same cycle.
- EX register clears (wb_valid=0) on any cycle with no completing instruction.
- An instruction that stalls behind MUL and depends on its rd receives the value via forwarding.
- Reset (rstn=0 at an edge): all registers 0, FSM IDLE, counter 0, stall 0, wb_valid 0, wb_addr 0, wb_data 0, flags 0. A multiply in progress is aborted with no writeback.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: MUL behaves as above.
- Undefined: no MUL FSM or counter is built; opcode 7 is treated as NOP; stall is tied 0.

Test Plan:
- Reset, then ADD r1=r0+imm 5 (src2_sel=1) -> wb_valid=1, wb_addr=1, wb_data=0x0005 next cycle; dbg r1=5 one cycle later.
- Back-to-back: r1=0x7FFF; then r2=r1+r1 issued the cycle after -> forwarded, wb_data=0xFFFE, carry=0; then r3=r2+r2 -> 0xFFFC, carry=1.
- SUB r4=r0-r1 with r1=1 -> 0xFFFF, carry(borrow)=1, zero=0; SUB r5=r1-r1 -> 0, zero=1.
- MUL r6=r2(0x0003)*r3(0x0007) accepted at T -> stall=1 for T+1..T+16, wb_data=0x0015 in T+17; dependent ADD r7=r6+r6 held until T+17 -> 0x002A.
- Reset asserted mid-MUL at T+5 -> stall=0, wb_valid=0, all registers read 0 via dbg_data, flags 0.
- Write to r0 (rd=0, reg_we=1, imm=9, out_sel=1) -> wb_valid=0, dbg r0=0; NOP opcode 12 with reg_we=1 -> no write, flags unchanged.
